// File: rtl/shf_d4c3_unshift_pkg.sv
// Shared op codes, FSM encoding and op-decode helpers for the iterative un-shifter.
package shf_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 2;

    localparam logic [OP_W-1:0] OP_PASS = 3'b000;
    localparam logic [OP_W-1:0] OP_SHL1 = 3'b001;
    localparam logic [OP_W-1:0] OP_SHL2 = 3'b010;
    localparam logic [OP_W-1:0] OP_SHR1 = 3'b011;
    localparam logic [OP_W-1:0] OP_SHR2 = 3'b100;
    localparam logic [OP_W-1:0] OP_SAR1 = 3'b101;
    localparam logic [OP_W-1:0] OP_ROL1 = 3'b110;
    localparam logic [OP_W-1:0] OP_ROR1 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of single-bit inverse steps needed for an op.
    function automatic logic [CNT_W-1:0] op_count(input logic [OP_W-1:0] s);
        case (s)
            OP_PASS:          return CNT_W'(0);
            OP_SHL2, OP_SHR2: return CNT_W'(2);
            default:          return CNT_W'(1);
        endcase
    endfunction

    function automatic logic op_lossy(input logic [OP_W-1:0] s);
        case (s)
            OP_SHL1, OP_SHL2, OP_SHR1, OP_SHR2, OP_SAR1: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    // Inverse of a right-going op (or ror) steps left.
    function automatic logic op_step_left(input logic [OP_W-1:0] s);
        case (s)
            OP_SHR1, OP_SHR2, OP_SAR1, OP_ROR1: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic op_step_rot(input logic [OP_W-1:0] s);
        return (s == OP_ROL1) || (s == OP_ROR1);
    endfunction

endpackage

// File: rtl/shf_d4c3_unshift_step.sv
// Combinational single-bit inverse step: shift or rotate one position left/right.
module shf_unshift_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] word,
    input  logic             left,
    input  logic             rot,
    output logic [WIDTH-1:0] next_word_c
);

    assign next_word_c = left ? {word[WIDTH-2:0], rot & word[WIDTH-1]}
                              : {rot & word[0], word[WIDTH-1:1]};

endmodule

// File: rtl/shf_d4c3_unshift.sv
// Iterative inverse of the 4-bit/3-op shifter, one bit per clock, valid/ready on both sides.
// Optional consistency check on the incoming image is enabled by SHF_INV_CHECK_EN.
module shf_d4c3_unshift
    import shf_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y,
    input  logic [OP_W-1:0]  s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             lossy,
    output logic             err
);

    state_t            state;
    logic [OP_W-1:0]   op;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  step_c;
    logic              chk_err_c;
    logic              accept_c;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept_c  = in_valid && in_ready;

`ifdef SHF_INV_CHECK_EN
    // Flags images no forward shift could have produced (vacated bits must be zero/sign).
    always_comb begin
        chk_err_c = 1'b0;
        case (s)
            OP_SHL1: chk_err_c = y[0];
            OP_SHL2: chk_err_c = |y[1:0];
            OP_SHR1: chk_err_c = y[WIDTH-1];
            OP_SHR2: chk_err_c = |y[WIDTH-1:WIDTH-2];
            OP_SAR1: chk_err_c = y[WIDTH-1] ^ y[WIDTH-2];
            default: chk_err_c = 1'b0;
        endcase
    end
`else
    assign chk_err_c = 1'b0;
`endif

    shf_unshift_step #(.WIDTH(WIDTH)) u_step (
        .word        (d_out),
        .left        (op_step_left(op)),
        .rot         (op_step_rot(op)),
        .next_word_c (step_c)
    );

    // d_out doubles as the work register; it is only advertised in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op    <= OP_PASS;
            cnt   <= '0;
            d_out <= '0;
            lossy <= 1'b0;
            err   <= 1'b0;
        end else if (accept_c) begin
            d_out <= y;
            op    <= s;
            cnt   <= op_count(s);
            lossy <= op_lossy(s);
            err   <= chk_err_c;
            state <= (op_count(s) != '0) ? ST_RUN : ST_DONE;
        end else if ((state == ST_DONE) && out_ready) begin
            state <= ST_IDLE;
        end else if (state == ST_RUN) begin
            d_out <= step_c;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state <= ST_DONE;
            end
        end
    end

endmodule

// File: tb/tb_shf_d4c3_unshift.sv
// Self-checking bench for shf_d4c3_unshift: directed table, corner sequences, loopback, random.
module tb_shf_d4c3_unshift;

`ifdef SHF_INV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] y = '0;
    logic [2:0] s = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] d_out;
    logic       lossy;
    logic       err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shf_d4c3_unshift #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .s(s), .out_valid(out_valid), .out_ready(out_ready),
        .d_out(d_out), .lossy(lossy), .err(err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Forward shifter, straight from the op table.
    function automatic logic [3:0] fwd(input logic [3:0] d, input logic [2:0] op);
        case (op)
            3'd0: return d;
            3'd1: return d << 1;
            3'd2: return d << 2;
            3'd3: return d >> 1;
            3'd4: return d >> 2;
            3'd5: return {d[3], d[3:1]};
            3'd6: return {d[2:0], d[3]};
            default: return {d[0], d[3:1]};
        endcase
    endfunction

    function automatic logic [3:0] inv(input logic [3:0] v, input logic [2:0] op);
        case (op)
            3'd0: return v;
            3'd1: return v >> 1;
            3'd2: return v >> 2;
            3'd3: return v << 1;
            3'd4: return v << 2;
            3'd5: return v << 1;
            3'd6: return {v[0], v[3:1]};
            default: return {v[2:0], v[3]};
        endcase
    endfunction

    function automatic logic [3:0] keep_mask(input logic [2:0] op);
        case (op)
            3'd1: return 4'b0111;
            3'd2: return 4'b0011;
            3'd3: return 4'b1110;
            3'd4: return 4'b1100;
            3'd5: return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        if (op == 3'd0) return 0;
        if (op == 3'd2 || op == 3'd4) return 2;
        return 1;
    endfunction

    function automatic logic exp_err(input logic [3:0] v, input logic [2:0] op);
        if (!CHK) return 1'b0;
        case (op)
            3'd1: return v[0];
            3'd2: return v[1:0] != 2'b00;
            3'd3: return v[3];
            3'd4: return v[3:2] != 2'b00;
            3'd5: return v[3] != v[2];
            default: return 1'b0;
        endcase
    endfunction

    // One transaction; junk stays on y/s with in_valid high while busy to prove it is ignored.
    task automatic run_txn(input logic [3:0] ty, input logic [2:0] ts, input int hold,
                           output logic [3:0] od, output logic ol, output logic oe,
                           output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1; y = ty; s = ts; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        y = 4'($urandom); s = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        od = d_out; ol = lossy; oe = err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_d", int'(d_out), int'(od));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0] y;
        logic [2:0] s;
        logic [3:0] d;
        logic       l;
        logic       e;
        int         lat;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [3:0] od;
        logic       ol, oe;
        int         lat;
        logic [3:0] ry;
        logic [2:0] rs;

        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] od;
        logic       ol, oe;
        int         lat;
        logic [3:0] ry, dd;
        logic [2:0] rs;

        vt[0] = '{4'b1101, 3'b111, 4'b1011, 1'b0, 1'b0, 1};
        vt[1] = '{4'b1000, 3'b010, 4'b0010, 1'b1, 1'b0, 2};
        vt[2] = '{4'b1001, 3'b010, 4'b0010, 1'b1, CHK,  2};
        vt[3] = '{4'b1101, 3'b101, 4'b1010, 1'b1, 1'b0, 1};
        vt[4] = '{4'b1001, 3'b101, 4'b0010, 1'b1, CHK,  1};
        vt[5] = '{4'b0111, 3'b000, 4'b0111, 1'b0, 1'b0, 0};
        vt[6] = '{4'b0100, 3'b100, 4'b0000, 1'b1, CHK,  2};
        vt[7] = '{4'b0011, 3'b011, 4'b0110, 1'b1, 1'b0, 1};
        vt[8] = '{4'b0011, 3'b110, 4'b1001, 1'b0, 1'b0, 1};
        vt[9] = '{4'b0110, 3'b001, 4'b0011, 1'b1, 1'b0, 1};

        // Reset state
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_d_out", int'(d_out), 0);
        check("rst_lossy", int'(lossy), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_txn(vt[i].y, vt[i].s, i % 3, od, ol, oe, lat);
            check("tbl_d", int'(od), int'(vt[i].d));
            check("tbl_lossy", int'(ol), int'(vt[i].l));
            check("tbl_err", int'(oe), int'(vt[i].e));
            check("tbl_lat", lat, vt[i].lat);
        end

        // Backpressure with next image waiting, then back-to-back accept
        @(negedge clk);
        in_valid = 1'b1; y = 4'b0111; s = 3'b000; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        y = 4'b0011; s = 3'b110;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_d", int'(d_out), 4'b0111);
            check("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("bp_in_ready_hs", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_busy", int'(out_valid), 0);
        @(negedge clk);
        check("b2b_valid", int'(out_valid), 1);
        check("b2b_d", int'(d_out), 4'b1001);
        check("b2b_lossy", int'(lossy), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during RUN
        in_valid = 1'b1; y = 4'b0100; s = 3'b100;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_d", int'(d_out), 0);
        check("mrst_lossy", int'(lossy), 0);
        check("mrst_err", int'(err), 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mrst_no_stale", int'(out_valid), 0);
            check("mrst_in_ready", int'(in_ready), 1);
        end

        // Exhaustive loopback through the forward model
        for (int op = 0; op < 8; op++) begin
            for (int d = 0; d < 16; d++) begin
                rs = 3'(op); dd = 4'(d);
                run_txn(fwd(dd, rs), rs, 0, od, ol, oe, lat);
                check("loop_d", int'(od), int'(dd & keep_mask(rs)));
                check("loop_err", int'(oe), 0);
                check("loop_lossy", int'(ol), int'(keep_mask(rs) != 4'b1111));
            end
        end

        // Random images, including inconsistent ones
        for (int i = 0; i < 150; i++) begin
            ry = 4'($urandom); rs = 3'($urandom);
            run_txn(ry, rs, $urandom_range(0, 3), od, ol, oe, lat);
            check("rnd_d", int'(od), int'(inv(ry, rs)));
            check("rnd_err", int'(oe), int'(exp_err(ry, rs)));
            check("rnd_lossy", int'(ol), int'(keep_mask(rs) != 4'b1111));
            check("rnd_lat", lat, exp_lat(rs));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
